// File: rtl/spi_master_ctrl_if.sv
// Host/serial bundle for the SPI initiator.
// The "master" modport is the controller's own view (it is the SPI master).
// The "slave" modport is the surrounding host sequencer plus the serial slave.
interface spi_master_ctrl_if;
    logic       start;
    logic [9:0] cmd;
    logic       busy;
    logic       done;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start,
        input  cmd,
        input  MISO,
        output busy,
        output done,
        output rd_valid,
        output rd_data,
        output SS_n,
        output MOSI
    );

    modport slave (
        output start,
        output cmd,
        output MISO,
        input  busy,
        input  done,
        input  rd_valid,
        input  rd_data,
        input  SS_n,
        input  MOSI
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI initiator: frames a 10-bit command as a select bit followed by the
// command MSB first.  For read-data commands it also shifts in one response
// byte.  Every output is registered; each next-state decision also sets the
// next value of each output, so the outputs change on the same edge as the
// state.
module spi_master_ctrl #(
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned TA_CYC   = 2,
    parameter int unsigned GAP_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_ctrl_if.master  bus
);

    localparam int unsigned OUT_LAST  = 9;
    localparam int unsigned IN_LAST   = 7;
    localparam int unsigned HOLD_LAST = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
    localparam int unsigned TA_LAST   = (TA_CYC > 0) ? TA_CYC - 1 : 0;
    localparam int unsigned GAP_LAST  = (GAP_CYC > 1) ? GAP_CYC - 2 : 0;
    localparam int unsigned MAX_A     = (HOLD_LAST > TA_LAST) ? HOLD_LAST : TA_LAST;
    localparam int unsigned MAX_B     = (MAX_A > GAP_LAST) ? MAX_A : GAP_LAST;
    localparam int unsigned MAX_CNT   = (MAX_B > OUT_LAST) ? MAX_B : OUT_LAST;
    localparam int unsigned CNT_W     = $clog2(MAX_CNT + 1);

    typedef enum logic [3:0] {
        IDLE,
        SELECT,
        CMD,
        SHIFT_OUT,
        HOLD,
        TURN,
        SHIFT_IN,
        FINISH,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       tx_q, tx_d;
    logic             rd_frame_q, rd_frame_d;
    logic [7:0]       rx_q, rx_d;
    logic             ss_n_q, ss_n_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_q       <= '0;
            rd_frame_q <= 1'b0;
            rx_q       <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rd_frame_q <= rd_frame_d;
            rx_q       <= rx_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rd_frame_d = rd_frame_q;
        rx_d       = rx_q;
        ss_n_d     = ss_n_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        case (state_q)
            IDLE: begin
                ss_n_d = 1'b1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (bus.start) begin
                    state_d    = SELECT;
                    tx_d       = bus.cmd;
                    rd_frame_d = (bus.cmd[9:8] == 2'b11);
                    ss_n_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            SELECT: begin
                state_d = CMD;
                mosi_d  = tx_q[9];
            end

            // Command-select bit is cmd[9]; the MSB then repeats as the first data bit
            CMD: begin
                state_d = SHIFT_OUT;
                mosi_d  = tx_q[9];
                cnt_d   = '0;
            end

            SHIFT_OUT: begin
                if (cnt_q == CNT_W'(OUT_LAST)) begin
                    cnt_d  = '0;
                    mosi_d = 1'b0;
                    if (rd_frame_q) begin
                        state_d = (TA_CYC == 0) ? SHIFT_IN : TURN;
                    end else if (HOLD_CYC == 0) begin
                        state_d = FINISH;
                        ss_n_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    tx_d   = {tx_q[8:0], 1'b0};
                    mosi_d = tx_q[8];
                end
            end

            HOLD: begin
                if (cnt_q == CNT_W'(HOLD_LAST)) begin
                    state_d = FINISH;
                    cnt_d   = '0;
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            TURN: begin
                if (cnt_q == CNT_W'(TA_LAST)) begin
                    state_d = SHIFT_IN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // MISO is captured MSB first at the end of each cycle
            SHIFT_IN: begin
                rx_d = {rx_q[6:0], bus.MISO};
                if (cnt_q == CNT_W'(IN_LAST)) begin
                    state_d    = FINISH;
                    cnt_d      = '0;
                    ss_n_d     = 1'b1;
                    done_d     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_data_d  = {rx_q[6:0], bus.MISO};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            FINISH: begin
                ss_n_d = 1'b1;
                mosi_d = 1'b0;
                cnt_d  = '0;
                if (GAP_CYC <= 1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = GAP;
                end
            end

            GAP: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.SS_n     = ss_n_q;
    assign bus.MOSI     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with default timing parameters.
// Inputs are driven on the falling edge and outputs are sampled there as well.
// Sample index k is the cycle t0+k, where t0 is the cycle whose closing edge accepts start.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_master_ctrl_if bus ();

    spi_master_ctrl #(
        .HOLD_CYC (2),
        .TA_CYC   (2),
        .GAP_CYC  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [9:0]  cmd;
        logic [7:0]  miso;
        logic [10:0] exp_mosi;
        bit          exp_rd;
        int          exp_end;
        logic [7:0]  exp_rd_data;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One complete frame with an optional start poke at t0+5 while busy
    task automatic run_frame(input vec_t v, input bit poke, input string tag);
        logic [10:0] mosi_got;
        logic [7:0]  rd_at_end;
        int ss_bad, idle_mosi_bad, done_cnt, done_at, rv_cnt, rv_at, busy_drop;
        mosi_got = '0; rd_at_end = '0;
        ss_bad = 0; idle_mosi_bad = 0; done_cnt = 0; done_at = -1;
        rv_cnt = 0; rv_at = -1; busy_drop = -1;

        @(negedge clk);
        bus.start = 1'b1;
        bus.cmd   = v.cmd;
        bus.MISO  = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus.start = (poke && k == 5);
            if (poke && k == 5) bus.cmd = 10'h3FF;
            bus.MISO = (k >= 15 && k <= 22) ? v.miso[22-k] : 1'b0;
            if (k >= 2 && k <= 12) mosi_got[12-k] = bus.MOSI;
            if (k < v.exp_end) begin
                if (bus.SS_n !== 1'b0) ss_bad++;
            end else if (bus.SS_n !== 1'b1) begin
                ss_bad++;
            end
            if (bus.SS_n === 1'b1 && bus.MOSI !== 1'b0) idle_mosi_bad++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (bus.rd_valid === 1'b1) begin
                rv_cnt++;
                if (rv_at < 0) rv_at = k;
            end
            if (k == v.exp_end) rd_at_end = bus.rd_data;
            if (busy_drop < 0 && bus.busy !== 1'b1) busy_drop = k;
        end

        check($sformatf("%s mosi_stream", tag), 32'(mosi_got), 32'(v.exp_mosi));
        check($sformatf("%s ss_window", tag), 32'(ss_bad), 32'd0);
        check($sformatf("%s mosi_zero_when_deselected", tag), 32'(idle_mosi_bad), 32'd0);
        check($sformatf("%s done_count", tag), 32'(done_cnt), 32'd1);
        check($sformatf("%s done_cycle", tag), 32'(done_at), 32'(v.exp_end));
        check($sformatf("%s rd_valid_count", tag), 32'(rv_cnt), v.exp_rd ? 32'd1 : 32'd0);
        check($sformatf("%s rd_valid_cycle", tag), 32'(rv_at), v.exp_rd ? 32'(v.exp_end) : 32'hFFFF_FFFF);
        check($sformatf("%s rd_data_at_end", tag), 32'(rd_at_end), 32'(v.exp_rd_data));
        check($sformatf("%s busy_drop_cycle", tag), 32'(busy_drop), 32'(v.exp_end + 1));
        check($sformatf("%s rd_data_held", tag), 32'(bus.rd_data), 32'(v.exp_rd_data));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int ss14, ss15, ss16, ss17, busy16, busy17, dcnt, busy_seen;

        // cmd, MISO byte, MOSI t0+2..t0+12, read-data, SS_n rise cycle, rd_data after frame
        vecs[0] = '{10'b00_1010_0101, 8'h00, 11'b000_1010_0101, 1'b0, 15, 8'h00};
        vecs[1] = '{10'b10_0000_1111, 8'h00, 11'b110_0000_1111, 1'b0, 15, 8'h00};
        vecs[2] = '{10'b11_0000_0000, 8'hB2, 11'b111_0000_0000, 1'b1, 23, 8'hB2};
        vecs[3] = '{10'b01_1100_0011, 8'h00, 11'b001_1100_0011, 1'b0, 15, 8'hB2};
        vecs[4] = '{10'b11_1010_1010, 8'h5A, 11'b111_1010_1010, 1'b1, 23, 8'h5A};
        vecs[5] = '{10'b01_0000_0001, 8'hFF, 11'b001_0000_0001, 1'b0, 15, 8'h5A};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.cmd   = '0;
        bus.MISO  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset SS_n", 32'(bus.SS_n), 32'd1);
        check("reset MOSI", 32'(bus.MOSI), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset rd_valid", 32'(bus.rd_valid), 32'd0);
        check("reset rd_data", 32'(bus.rd_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Start with cmd=3FF during a write frame must be ignored
        run_frame('{10'b00_1010_0101, 8'h00, 11'b000_1010_0101, 1'b0, 15, 8'h5A}, 1'b1, "busy_poke");

        // Back-to-back: start held high, second SELECT at t0+17
        ss14 = 0; ss15 = 0; ss16 = 0; ss17 = 0; busy16 = 0; busy17 = 0; dcnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.cmd   = 10'b00_1010_0101;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 17) bus.start = 1'b0;
            if (bus.done === 1'b1) dcnt++;
            if (k == 14) ss14 = int'(bus.SS_n);
            if (k == 15) ss15 = int'(bus.SS_n);
            if (k == 16) begin ss16 = int'(bus.SS_n); busy16 = int'(bus.busy); end
            if (k == 17) begin ss17 = int'(bus.SS_n); busy17 = int'(bus.busy); end
        end
        check("b2b ss_t14", 32'(ss14), 32'd0);
        check("b2b ss_t15", 32'(ss15), 32'd1);
        check("b2b ss_t16", 32'(ss16), 32'd1);
        check("b2b ss_t17", 32'(ss17), 32'd0);
        check("b2b busy_t16", 32'(busy16), 32'd0);
        check("b2b busy_t17", 32'(busy17), 32'd1);
        check("b2b first_done_count", 32'(dcnt), 32'd1);
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
        end
        check("b2b second_done_count", 32'(dcnt), 32'd1);
        check("b2b idle_after", 32'(bus.busy), 32'd0);

        // Reset held for three cycles from t0+17 of a read-data frame
        dcnt = 0; busy_seen = 0; ss16 = 1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.cmd   = 10'b11_0000_0000;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus.start = (k == 18);
            bus.MISO  = (k >= 15 && k <= 22) ? vecs[2].miso[22-k] : 1'b0;
            if (k == 17) rst = 1'b1;
            if (k == 20) rst = 1'b0;
            if (k == 16) ss16 = int'(bus.SS_n);
            if (bus.done === 1'b1 || bus.rd_valid === 1'b1) dcnt++;
            if (k >= 18 && bus.busy !== 1'b0) busy_seen++;
            if (k == 18) begin
                check("midrst SS_n", 32'(bus.SS_n), 32'd1);
                check("midrst MOSI", 32'(bus.MOSI), 32'd0);
                check("midrst busy", 32'(bus.busy), 32'd0);
                check("midrst rd_valid", 32'(bus.rd_valid), 32'd0);
                check("midrst rd_data", 32'(bus.rd_data), 32'd0);
            end
        end
        check("midrst frame_active_before", 32'(ss16), 32'd0);
        check("midrst no_done_or_rd_valid", 32'(dcnt), 32'd0);
        check("midrst start_ignored_in_reset", 32'(busy_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Initiator end of the 4-wire-less SPI link: drives SS_n and MOSI and samples MISO. All three signals are synchronous to the shared system clock.
- Takes a 10-bit command word from the host side and serialises it with the same framing the slave expects:
  - One command-select bit.
  - Then 10 bits, MSB first.
- For read-data commands (cmd[9:8]=2'b11), it also shifts in one 8-bit response byte and returns it to the host.
- Sits between the host/test sequencer and the SPI slave + RAM subsystem.

Parameters:
- HOLD_CYC, 2: cycles SS_n is held low after the last MOSI bit of a non-read-data frame. This lets the slave raise rx_valid.
- TA_CYC, 2: turnaround cycles between the last MOSI bit and the first MISO sample in a read-data frame.
- GAP_CYC, 1: minimum cycles SS_n stays high after a frame before the next start is accepted. Must be ≥1.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a frame. Sampled only when busy=0.
- cmd, input, 10: command word. cmd[9:8] is the op, cmd[7:0] is the payload. Captured on the accepted start cycle.
- busy, output, 1: high from the cycle after start is accepted until the gap ends.
- done, output, 1: one-cycle pulse when a frame ends.
- rd_valid, output, 1: one-cycle pulse with the read byte; read-data frames only.
- rd_data, output, 8: read byte. Holds its value until the next read-data frame completes.
- SS_n, output, 1: slave select, active low.
- MOSI, output, 1: serial data to the slave.
- MISO, input, 1: serial data from the slave.

Behaviour:
- Reset (rst=1 at a rising edge) takes effect that edge:
  - SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, state=IDLE, all counters 0.
  - Applies mid-frame too: the frame is aborted with no done and no rd_valid.
  - start is ignored in any cycle where rst=1.
- States: IDLE, SELECT, CMD, SHIFT_OUT, HOLD, TURN, SHIFT_IN, FINISH, GAP.
- Frame timing; t0 is the cycle in which start=1 is sampled in IDLE:
  - IDLE: SS_n=1, MOSI=0. start=1 latches cmd and moves to SELECT.
  - SELECT (t0+1): SS_n=0, MOSI=0, busy=1.
  - CMD (t0+2): MOSI=cmd[9]. This is the command-select bit: 0 means write-type, 1 means read-type.
  - SHIFT_OUT (t0+3..t0+12): MOSI=cmd[9-k] for k=0..9. cmd[9] is therefore sent twice, by design of the frame.
  - If cmd[9:8]!=2'b11: HOLD for HOLD_CYC cycles (SS_n=0, MOSI=0), then FINISH.
  - If cmd[9:8]==2'b11: TURN for TA_CYC cycles (SS_n=0, MOSI=0), then SHIFT_IN.
  - SHIFT_IN: 8 cycles. The MISO value at the end of the k-th cycle (k=0..7) is captured as shift bit 7-k, MSB first.
  - FINISH: one cycle.
    - SS_n=1 and done=1.
    - For read-data frames only: rd_valid=1 and rd_data is updated in the same cycle.
  - GAP: GAP_CYC-1 further cycles with SS_n=1 and busy=1, then IDLE.
- Latencies with defaults:
  - Write-type: SS_n low t0+1..t0+14; done at t0+15; busy drops at t0+16.
  - Read-data: SS_n low t0+1..t0+22; done and rd_valid at t0+23; busy drops at t0+24.
- Handshake rules:
  - start while busy=1 is ignored; there is no queuing.
  - Changes on cmd after t0 have no effect.
  - start in the same cycle busy falls to 0 is accepted (IDLE evaluates it).
- Counters are sized to ceil(log2(max count+1)). They must not wrap within any parameter-legal frame.
- MOSI is 0 whenever SS_n=1.

Test Plan:
- Reset: hold rst 3 cycles during a read-data frame at t0+17 → next cycle SS_n=1, MOSI=0, busy=0, rd_valid=0, rd_data=0; no done pulse.
- Write address: cmd=10'b00_1010_0101, start at t0 → MOSI t0+2..t0+12 = 0,0,0,1,0,1,0,0,1,0,1; SS_n rises t0+15; done=1 at t0+15 only; rd_valid stays 0.
- Read address: cmd=10'b10_0000_1111 → MOSI t0+2 = 1; SS_n low for 14 cycles; no SHIFT_IN; rd_data unchanged.
- Read data: cmd=10'b11_0000_0000, slave model drives MISO 1,0,1,1,0,0,1,0 in t0+15..t0+22 → rd_valid=1 and rd_data=8'hB2 at t0+23; SS_n=1 at t0+23.
- Start while busy: pulse start with cmd=10'h3FF at t0+5 during a write frame → ignored; MOSI stream unchanged; only one done.
- Back-to-back: start held high continuously → second frame's SELECT at t0+17 (GAP_CYC=1); SS_n high for exactly 2 cycles (t0+15, t0+16).
